apu_dmc_reader: RTL and testbench

Memory-reader controller for the APU delta-modulation channel. Owns the DMC register file ($4010/$4012/$4013 and $4015 bit 4), sequences one-byte sample fetches through the DMA engine, holds the one-byte sample buffer for the DMC output unit, and raises the DMC IRQ. Sits between the CPU register decode, the DMA engine's `dmc_*` port group and the DMC output unit.

---
 rtl/apu_dmc_reader_if.sv | 23 ++
 rtl/apu_dmc_reader.sv | 155 +++++++++++++++
 tb/tb_apu_dmc_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_dmc_reader_if.sv
// DMC reader <-> DMA engine / DMC output unit signal group.
// master = reader side, slave = DMA engine and output unit side.
interface apu_dmc_reader_if;
  // dmc_req is a one-cycle request. The DMA answers later with a single dmc_read cycle.
  // out_take is a one-cycle consume pulse, and out_full/out_data hold the buffered byte.
  logic       dmc_addr_wr;
  logic       dmc_init;
  logic       dmc_req;
  logic       dmc_read;
  logic       out_take;
  logic       out_full;
  logic [7:0] out_data;

  modport master (
    output dmc_addr_wr, dmc_init, dmc_req, out_full, out_data,
    input  dmc_read, out_take
  );

  modport slave (
    input  dmc_addr_wr, dmc_init, dmc_req, out_full, out_data,
    output dmc_read, out_take
  );
endinterface

// File: rtl/apu_dmc_reader.sv
// APU DMC memory reader: register file, one-byte fetch sequencing through the DMA,
// sample buffer and DMC IRQ.
module apu_dmc_reader (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_ce,
  input  logic                    rw_i,
  input  logic [15:0]             cpu_addr_i,
  input  logic [7:0]              cpu_data_i,
  input  logic [7:0]              bus_data_i,
  apu_dmc_reader_if.master        dmc,
  output logic [3:0]              rate_idx,
  output logic                    dmc_busy,
  output logic                    dmc_irq,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        was_wait_q;
  logic        irq_en_q, irq_en_d;
  logic        loop_q, loop_d;
  logic [3:0]  rate_q, rate_d;
  logic [7:0]  len_q, len_d;
  logic [11:0] rem_q, rem_d;
  logic        irq_q, irq_d;
  logic        full_q, full_d;
  logic [7:0]  data_q, data_d;
  logic        init_c;
  logic        req_c;

  logic        wr_c;
  logic        w4010_c, w4012_c, w4013_c, w4015_c;
  logic        rd_cap_c;
  logic [11:0] length_c;
  logic [11:0] rem_dec_c;

  assign wr_c      = cpu_ce && !rw_i;
  assign w4010_c   = wr_c && (cpu_addr_i == 16'h4010);
  assign w4012_c   = wr_c && (cpu_addr_i == 16'h4012);
  assign w4013_c   = wr_c && (cpu_addr_i == 16'h4013);
  assign w4015_c   = wr_c && (cpu_addr_i == 16'h4015);
  assign rd_cap_c  = (state_q == S_WAIT) && dmc.dmc_read;
  assign length_c  = {len_q, 4'b0000} + 12'd1;
  assign rem_dec_c = rem_q - 12'd1;

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    case (state_q)
      S_IDLE: if (!full_q && (rem_q != 12'd0) && !was_wait_q) state_d = S_REQ;
      S_REQ: begin
        req_c   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (dmc.dmc_read) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    irq_en_d = irq_en_q;
    loop_d   = loop_q;
    rate_d   = rate_q;
    len_d    = len_q;
    rem_d    = rem_q;
    irq_d    = irq_q;
    full_d   = full_q;
    data_d   = data_q;
    init_c   = 1'b0;

    // A capture in the same cycle as out_take leaves the buffer full with the new byte.
    if (rd_cap_c) begin
      data_d = bus_data_i;
      full_d = 1'b1;
    end else if (dmc.out_take) begin
      full_d = 1'b0;
    end

    if (rd_cap_c && (rem_q != 12'd0)) begin
      rem_d = rem_dec_c;
      if (rem_dec_c == 12'd0) begin
        if (loop_q) begin
          rem_d  = length_c;
          init_c = 1'b1;
        end else if (irq_en_q) begin
          irq_d = 1'b1;
        end
      end
    end

    if (w4010_c) begin
      irq_en_d = cpu_data_i[7];
      loop_d   = cpu_data_i[6];
      rate_d   = cpu_data_i[3:0];
      if (!cpu_data_i[7]) irq_d = 1'b0;
    end

    if (w4013_c) len_d = cpu_data_i;

    // Applied last so a $4015 write overrides a same-cycle final fetch.
    if (w4015_c) begin
      irq_d = 1'b0;
      if (!cpu_data_i[4]) begin
        rem_d  = 12'd0;
        init_c = 1'b0;
      end else if (rem_q == 12'd0) begin
        rem_d  = length_c;
        init_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      was_wait_q <= 1'b0;
      irq_en_q   <= 1'b0;
      loop_q     <= 1'b0;
      rate_q     <= 4'd0;
      len_q      <= 8'd0;
      rem_q      <= 12'd0;
      irq_q      <= 1'b0;
      full_q     <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      was_wait_q <= (state_q == S_WAIT);
      irq_en_q   <= irq_en_d;
      loop_q     <= loop_d;
      rate_q     <= rate_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      irq_q      <= irq_d;
      full_q     <= full_d;
      data_q     <= data_d;
    end
  end

  assign dmc.dmc_addr_wr = w4012_c;
  assign dmc.dmc_init    = init_c;
  assign dmc.dmc_req     = req_c;
  assign dmc.out_full    = full_q;
  assign dmc.out_data    = data_q;
  assign rate_idx        = rate_q;
  assign dmc_busy        = (rem_q != 12'd0);
  assign dmc_irq         = irq_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_apu_dmc_reader.sv
// Directed bench for apu_dmc_reader: a per-cycle vector table followed by
// hand-written sequences for depletion, loop, disable and reset corner cases.
module tb_apu_dmc_reader;

  logic        clk;
  logic        rst;
  logic        cpu_ce;
  logic        rw_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic [7:0]  bus_data_i;
  logic [3:0]  rate_idx;
  logic        dmc_busy;
  logic        dmc_irq;
  logic [1:0]  state_o;

  apu_dmc_reader_if dif ();

  apu_dmc_reader dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce     (cpu_ce),
    .rw_i       (rw_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .bus_data_i (bus_data_i),
    .dmc        (dif.master),
    .rate_idx   (rate_idx),
    .dmc_busy   (dmc_busy),
    .dmc_irq    (dmc_irq),
    .state_o    (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int req_cnt   = 0;
  int dbl_cnt   = 0;
  logic prev_req = 1'b0;

  // combinational outputs sampled mid-cycle by cyc()
  logic s_init, s_awr, s_req;

  always @(negedge clk) begin
    if (dif.dmc_req) req_cnt++;
    if (dif.dmc_req && prev_req) dbl_cnt++;
    prev_req = dif.dmc_req;
  end

  typedef struct {
    logic        ce;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  bus;
    logic        rd;
    logic        take;
    logic        e_init;
    logic        e_awr;
    logic        e_req;
    logic        e_full;
    logic [7:0]  e_data;
    logic [3:0]  e_rate;
    logic        e_busy;
    logic        e_irq;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver: inputs change at posedge+1, comb outputs sampled at negedge,
  // registered outputs valid on return (posedge+1)
  task automatic cyc(input logic ce, input logic rw, input logic [15:0] addr,
                     input logic [7:0] wdata, input logic [7:0] bus,
                     input logic rd, input logic take);
    cpu_ce       = ce;
    rw_i         = rw;
    cpu_addr_i   = addr;
    cpu_data_i   = wdata;
    bus_data_i   = bus;
    dif.dmc_read = rd;
    dif.out_take = take;
    @(negedge clk);
    s_init = dif.dmc_init;
    s_awr  = dif.dmc_addr_wr;
    s_req  = dif.dmc_req;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    cyc(1'b1, 1'b0, addr, data, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rd_byte(input logic [7:0] b);
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, b, 1'b1, 1'b0);
  endtask

  task automatic take();
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  // bounded wait until the FSM is in WAIT
  task automatic wait_wait(input string name);
    int n;
    n = 0;
    while (state_o != 2'd2 && n < 20) begin
      idle();
      n++;
    end
    chk(name, {15'd0, state_o == 2'd2}, 16'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_wr"}, {15'd0, dif.dmc_addr_wr}, 16'd0);
    chk({tag, "_init"},    {15'd0, dif.dmc_init}, 16'd0);
    chk({tag, "_req"},     {15'd0, dif.dmc_req}, 16'd0);
    chk({tag, "_full"},    {15'd0, dif.out_full}, 16'd0);
    chk({tag, "_data"},    {8'd0, dif.out_data}, 16'd0);
    chk({tag, "_rate"},    {12'd0, rate_idx}, 16'd0);
    chk({tag, "_busy"},    {15'd0, dmc_busy}, 16'd0);
    chk({tag, "_irq"},     {15'd0, dmc_irq}, 16'd0);
  endtask

  int base;

  initial begin
    rst = 1'b1;
    cpu_ce = 1'b0; rw_i = 1'b1; cpu_addr_i = '0; cpu_data_i = '0; bus_data_i = '0;
    dif.dmc_read = 1'b0; dif.out_take = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // ---- reset in the middle of WAIT ----
    wr(16'h4010, 8'h8F);
    wr(16'h4013, 8'h01);
    wr(16'h4015, 8'h10);
    wait_wait("rst_reach_wait");
    chk("pre_rst_busy", {15'd0, dmc_busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = req_cnt;
    repeat (20) idle();
    chk("post_rst_no_req", req_cnt - base, 16'd0);

    // ---- vector table: start, first fetch, ignored read, take -> req 2 later ----
    //          ce   rw   addr     wd     bus    rd   tk   init awr  req  full data   rate busy irq
    vecs[0]  = '{1'b1,1'b0,16'h4013,8'h01,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,4'h0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,16'h4012,8'h55,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,4'h0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,16'h4010,8'h8F,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,4'hF,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b0,16'h4015,8'h10,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,4'hF,1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,4'hF,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,4'hF,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,4'hF,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,16'h0000,8'h00,8'hA5,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,8'hA5,4'hF,1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b1,16'h0000,8'h00,8'h77,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,8'hA5,4'hF,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'hA5,4'hF,1'b1,1'b0};
    vecs[10] = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hA5,4'hF,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'hA5,4'hF,1'b1,1'b0};
    vecs[12] = '{1'b0,1'b1,16'h0000,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'hA5,4'hF,1'b1,1'b0};

    base = req_cnt;
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].ce, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].bus,
          vecs[i].rd, vecs[i].take);
      chk($sformatf("v%0d_init", i), {15'd0, s_init}, {15'd0, vecs[i].e_init});
      chk($sformatf("v%0d_awr", i),  {15'd0, s_awr},  {15'd0, vecs[i].e_awr});
      chk($sformatf("v%0d_req", i),  {15'd0, s_req},  {15'd0, vecs[i].e_req});
      chk($sformatf("v%0d_full", i), {15'd0, dif.out_full}, {15'd0, vecs[i].e_full});
      chk($sformatf("v%0d_data", i), {8'd0, dif.out_data}, {8'd0, vecs[i].e_data});
      chk($sformatf("v%0d_rate", i), {12'd0, rate_idx}, {12'd0, vecs[i].e_rate});
      chk($sformatf("v%0d_busy", i), {15'd0, dmc_busy}, {15'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_irq", i),  {15'd0, dmc_irq}, {15'd0, vecs[i].e_irq});
    end

    // ---- drain the remaining 16 bytes of the 17-byte sample ----
    for (int i = 0; i < 16; i++) begin
      wait_wait($sformatf("drain%0d_wait", i));
      rd_byte(8'h10 + 8'(i));
      chk($sformatf("drain%0d_data", i), {8'd0, dif.out_data}, {8'd0, 8'h10 + 8'(i)});
      if (i == 0) begin
        int hold;
        hold = req_cnt;
        repeat (8) idle();
        chk("full_hold_no_req", req_cnt - hold, 16'd0);
      end
      if (i == 15) begin
        chk("last_busy", {15'd0, dmc_busy}, 16'd0);
        chk("last_irq",  {15'd0, dmc_irq}, 16'd1);
      end else begin
        chk($sformatf("drain%0d_busy", i), {15'd0, dmc_busy}, 16'd1);
      end
      take();
    end
    repeat (20) idle();
    chk("total_req_17", req_cnt - base, 16'd17);
    chk("no_double_req", dbl_cnt, 16'd0);
    chk("idle_irq_held", {15'd0, dmc_irq}, 16'd1);

    // ---- loop mode: single-byte sample reloads on every fetch ----
    do_reset();
    base = req_cnt;
    wr(16'h4010, 8'h40);
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    chk("loop_start_init", {15'd0, s_init}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      wait_wait($sformatf("loop%0d_wait", i));
      rd_byte(8'h60 + 8'(i));
      chk($sformatf("loop%0d_init", i), {15'd0, s_init}, 16'd1);
      chk($sformatf("loop%0d_busy", i), {15'd0, dmc_busy}, 16'd1);
      chk($sformatf("loop%0d_irq", i),  {15'd0, dmc_irq}, 16'd0);
      chk($sformatf("loop%0d_data", i), {8'd0, dif.out_data}, {8'd0, 8'h60 + 8'(i)});
      take();
    end
    wait_wait("loop_continues");
    chk("loop_req_cnt", req_cnt - base, 16'd4);

    // ---- IRQ clear and disable with a fetch in flight ----
    do_reset();
    wr(16'h4010, 8'h80);
    wr(16'h4013, 8'h00);
    wr(16'h4015, 8'h10);
    wait_wait("dis_wait0");
    rd_byte(8'h11);
    chk("dis_irq_set", {15'd0, dmc_irq}, 16'd1);
    chk("dis_busy0",   {15'd0, dmc_busy}, 16'd0);
    take();
    wr(16'h4015, 8'h00);
    chk("dis_irq_clr",  {15'd0, dmc_irq}, 16'd0);
    chk("dis_busy_clr", {15'd0, dmc_busy}, 16'd0);
    wr(16'h4015, 8'h10);
    chk("restart_init", {15'd0, s_init}, 16'd1);
    chk("restart_busy", {15'd0, dmc_busy}, 16'd1);
    wait_wait("dis_wait1");
    wr(16'h4015, 8'h00);
    chk("inflight_busy", {15'd0, dmc_busy}, 16'd0);
    base = req_cnt;
    rd_byte(8'h3C);
    chk("inflight_init", {15'd0, s_init}, 16'd0);
    chk("inflight_full", {15'd0, dif.out_full}, 16'd1);
    chk("inflight_data", {8'd0, dif.out_data}, 16'h003C);
    chk("inflight_irq",  {15'd0, dmc_irq}, 16'd0);
    take();
    repeat (20) idle();
    chk("dis_no_req", req_cnt - base, 16'd0);
    chk("dis_full_clr", {15'd0, dif.out_full}, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
